// File: rtl/pixel_frame_buffer_pkg.sv
// Shared types and constants for the double-buffered 8x8 pixel frame buffer.
package pixel_frame_buffer_pkg;

    localparam int GRID_BITS   = 3;
    localparam int GRID_PIXELS = 64;
    localparam int ROW_PIXELS  = 8;

    typedef enum logic [1:0] {
        ST_DRAW  = 2'd0,
        ST_SWAP  = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

    typedef logic [GRID_BITS-1:0]   coord_t;
    typedef logic [2*GRID_BITS-1:0] pix_idx_t;

    // Linear bit index of pixel {row, column} in a 64-bit buffer.
    function automatic pix_idx_t pix_idx(input coord_t row, input coord_t col);
        return {row, col};
    endfunction

endpackage

// File: rtl/led_row_scanner.sv
// Row scanner: picks the displayed row (auto-refresh divider or manual select)
// and registers that front-buffer row onto the LED bank with a one-hot row strobe.
module led_row_scanner
    import pixel_frame_buffer_pkg::*;
#(
    parameter int SCAN_DIV = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [GRID_PIXELS-1:0] front,
    input  logic                   manual_sel,
    input  coord_t                 sel,
    output logic [ROW_PIXELS-1:0]  led,
    output logic [ROW_PIXELS-1:0]  row_sel
);

    logic [15:0]           div_q, div_d;
    coord_t                row_q, row_d;
    coord_t                disp_row;
    logic [ROW_PIXELS-1:0] led_q, led_d;
    logic [ROW_PIXELS-1:0] row_sel_q, row_sel_d;

    always_comb begin
        // NOTE: every signal gets a default before the branches, so no latch is inferred.
        div_d = div_q;
        row_d = row_q;
        if (!manual_sel) begin
            if (div_q == 16'(SCAN_DIV - 1)) begin
                div_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                div_d = div_q + 16'd1;
            end
        end
        disp_row  = manual_sel ? sel : row_q;
        led_d     = front[{disp_row, 3'b000} +: ROW_PIXELS];
        row_sel_d = 8'd1 << disp_row;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            row_q     <= '0;
            led_q     <= '0;
            row_sel_q <= 8'h01;
        end else begin
            div_q     <= div_d;
            row_q     <= row_d;
            led_q     <= led_d;
            row_sel_q <= row_sel_d;
        end
    end

    assign led     = led_q;
    assign row_sel = row_sel_q;

endmodule

// File: rtl/pixel_frame_buffer.sv
// Double-buffered 8x8 1-bit frame buffer fed by the accelerator: draw into back,
// copy to front on each RenderEnd rising edge, optionally clear back, scan front out.
module pixel_frame_buffer
    import pixel_frame_buffer_pkg::*;
#(
    parameter int SCAN_DIV      = 16,
    parameter int CLEAR_ON_SWAP = 1
) (
    input  logic         ACLK,
    input  logic         ARESETn,
    input  logic [2:0]   xAddr,
    input  logic [2:0]   yAddr,
    input  logic         Write,
    input  logic         RenderEnd,
    input  logic         ManualSel,
    input  logic [2:0]   sel,
    output logic [7:0]   LED,
    output logic [7:0]   RowSel,
    output logic         Busy,
    output logic [7:0]   FrameCount,
    output logic         Overrun
);

    state_e                 state_q, state_d;
    logic [GRID_PIXELS-1:0] back_q, back_d;
    logic [GRID_PIXELS-1:0] front_q, front_d;
    coord_t                 clr_row_q, clr_row_d;
    logic                   pend_valid_q, pend_valid_d;
    pix_idx_t               pend_addr_q, pend_addr_d;
    logic                   swap_pend_q, swap_pend_d;
    logic [7:0]             frame_count_q, frame_count_d;
    logic                   overrun_q, overrun_d;
    logic                   re_d_q;
    logic                   busy_q;
    logic                   swap_req;
    pix_idx_t               wr_idx;

    assign swap_req = RenderEnd & ~re_d_q;
    assign wr_idx   = pix_idx(xAddr, yAddr);

    // State register; Busy is registered from the next state so it tracks state_q exactly.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= ST_DRAW;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != ST_DRAW);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_DRAW:  if (swap_req || swap_pend_q) state_d = ST_SWAP;
            ST_SWAP:  state_d = (CLEAR_ON_SWAP != 0) ? ST_CLEAR : ST_DRAW;
            ST_CLEAR: if (clr_row_q == 3'd7) state_d = ST_DRAW;
            default:  state_d = ST_DRAW;
        endcase
    end

    always_comb begin
        back_d        = back_q;
        front_d       = front_q;
        clr_row_d     = clr_row_q;
        pend_valid_d  = pend_valid_q;
        pend_addr_d   = pend_addr_q;
        swap_pend_d   = swap_pend_q;
        frame_count_d = frame_count_q;
        overrun_d     = overrun_q;
        case (state_q)
            ST_DRAW: begin
                if (pend_valid_q) begin
                    back_d[pend_addr_q] = 1'b1;
                    pend_valid_d        = 1'b0;
                end
                if (Write) back_d[wr_idx] = 1'b1;
                swap_pend_d = 1'b0;
            end
            ST_SWAP: begin
                if (Write) back_d[wr_idx] = 1'b1;
                front_d       = back_d;
                frame_count_d = frame_count_q + 8'd1;
                clr_row_d     = '0;
            end
            ST_CLEAR: begin
                back_d[{clr_row_q, 3'b000} +: ROW_PIXELS] = '0;
                clr_row_d = clr_row_q + 1'b1;
                // Writes held off until DRAW so the clear sweep cannot erase them.
                if (Write) begin
                    if (pend_valid_q) begin
                        overrun_d = 1'b1;
                    end else begin
                        pend_valid_d = 1'b1;
                        pend_addr_d  = wr_idx;
                    end
                end
            end
            default: ;
        endcase
        if ((state_q != ST_DRAW) && swap_req) begin
            if (swap_pend_q) overrun_d   = 1'b1;
            else             swap_pend_d = 1'b1;
        end
    end

    // NOTE: the frame buffers are flop arrays, not RAM, so they clear on reset like any register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            back_q        <= '0;
            front_q       <= '0;
            clr_row_q     <= '0;
            pend_valid_q  <= 1'b0;
            pend_addr_q   <= '0;
            swap_pend_q   <= 1'b0;
            frame_count_q <= '0;
            overrun_q     <= 1'b0;
            re_d_q        <= 1'b0;
        end else begin
            back_q        <= back_d;
            front_q       <= front_d;
            clr_row_q     <= clr_row_d;
            pend_valid_q  <= pend_valid_d;
            pend_addr_q   <= pend_addr_d;
            swap_pend_q   <= swap_pend_d;
            frame_count_q <= frame_count_d;
            overrun_q     <= overrun_d;
            re_d_q        <= RenderEnd;
        end
    end

    led_row_scanner #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scanner (
        .clk        (ACLK),
        .rst_n      (ARESETn),
        .front      (front_q),
        .manual_sel (ManualSel),
        .sel        (sel),
        .led        (LED),
        .row_sel    (RowSel)
    );

    assign Busy       = busy_q;
    assign FrameCount = frame_count_q;
    assign Overrun    = overrun_q;

endmodule

// File: tb/tb_pixel_frame_buffer.sv
// Scoreboard bench for pixel_frame_buffer: expectations are queued as stimulus is
// driven and popped against the port values when the design should show them.
module tb_pixel_frame_buffer;

    logic       ACLK = 1'b0;
    logic       ARESETn;
    logic [2:0] xAddr, yAddr, sel;
    logic       Write, RenderEnd, ManualSel;
    logic [7:0] LED, RowSel, FrameCount;
    logic       Busy, Overrun;

    typedef struct {
        string      scen;
        string      port;
        logic [7:0] val;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    logic [7:0] o;
    int         n_vec = 0;
    int         n_bad = 0;

    pixel_frame_buffer #(
        .SCAN_DIV      (4),
        .CLEAR_ON_SWAP (1)
    ) dut (
        .ACLK       (ACLK),
        .ARESETn    (ARESETn),
        .xAddr      (xAddr),
        .yAddr      (yAddr),
        .Write      (Write),
        .RenderEnd  (RenderEnd),
        .ManualSel  (ManualSel),
        .sel        (sel),
        .LED        (LED),
        .RowSel     (RowSel),
        .Busy       (Busy),
        .FrameCount (FrameCount),
        .Overrun    (Overrun)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] port_val(input string p);
        if (p == "LED")        return LED;
        if (p == "RowSel")     return RowSel;
        if (p == "Busy")       return {7'b0, Busy};
        if (p == "FrameCount") return FrameCount;
        if (p == "Overrun")    return {7'b0, Overrun};
        return 8'hxx;
    endfunction

    task automatic push(input string scen, input string port, input logic [7:0] val);
        exp_t x;
        x.scen = scen;
        x.port = port;
        x.val  = val;
        exp_q.push_back(x);
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_reset();
        ARESETn   = 1'b0;
        Write     = 1'b0;
        RenderEnd = 1'b0;
        ManualSel = 1'b1;
        sel       = 3'd0;
        xAddr     = 3'd0;
        yAddr     = 3'd0;
        repeat (2) tick();
        ARESETn = 1'b1;
        tick();
    endtask

    task automatic write_px(input logic [2:0] x, input logic [2:0] y);
        xAddr = x;
        yAddr = y;
        Write = 1'b1;
        tick();
        Write = 1'b0;
    endtask

    task automatic pulse_render();
        RenderEnd = 1'b1;
        tick();
        RenderEnd = 1'b0;
        tick();
    endtask

    // Wait until Busy has stayed low for three cycles; a timeout is a miscompare.
    task automatic settle(input string scen);
        int quiet = 0;
        for (int i = 0; i < 100 && quiet < 3; i++) begin
            tick();
            quiet = Busy ? 0 : quiet + 1;
        end
        if (quiet < 3) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s settle: Busy still high after 100 cycles", scen);
        end
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        push("reset", "LED", 8'h00);
        push("reset", "RowSel", 8'h01);
        push("reset", "Busy", 8'h00);
        push("reset", "FrameCount", 8'h00);
        push("reset", "Overrun", 8'h00);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = port_val(e.port); n_vec++;
            if (o !== e.val) begin n_bad++; $display("FAIL %s %s: got %h want %h", e.scen, e.port, o, e.val); end
        end
    endtask

    task automatic test_swap_clear();
        do_reset();
        sel = 3'd2;
        write_px(3'd2, 3'd3);
        pulse_render();
        settle("swap");
        push("swap", "LED", 8'h08);
        push("swap", "FrameCount", 8'h01);
        push("swap", "Busy", 8'h00);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = port_val(e.port); n_vec++;
            if (o !== e.val) begin n_bad++; $display("FAIL %s %s: got %h want %h", e.scen, e.port, o, e.val); end
        end
        pulse_render();
        settle("swap2");
        push("swap2_cleared", "LED", 8'h00);
        push("swap2_cleared", "FrameCount", 8'h02);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = port_val(e.port); n_vec++;
            if (o !== e.val) begin n_bad++; $display("FAIL %s %s: got %h want %h", e.scen, e.port, o, e.val); end
        end
    endtask

    task automatic test_pending_write();
        do_reset();
        sel = 3'd5;
        pulse_render();
        repeat (3) tick();
        write_px(3'd5, 3'd1);
        write_px(3'd6, 3'd6);
        push("pend", "Overrun", 8'h01);
        push("pend", "Busy", 8'h01);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = port_val(e.port); n_vec++;
            if (o !== e.val) begin n_bad++; $display("FAIL %s %s: got %h want %h", e.scen, e.port, o, e.val); end
        end
        settle("pend");
        pulse_render();
        settle("pend_swap");
        push("pend_row5", "LED", 8'h02);
        push("pend_row5", "FrameCount", 8'h02);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = port_val(e.port); n_vec++;
            if (o !== e.val) begin n_bad++; $display("FAIL %s %s: got %h want %h", e.scen, e.port, o, e.val); end
        end
        sel = 3'd6;
        repeat (2) tick();
        push("pend_row6_dropped", "LED", 8'h00);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = port_val(e.port); n_vec++;
            if (o !== e.val) begin n_bad++; $display("FAIL %s %s: got %h want %h", e.scen, e.port, o, e.val); end
        end
    endtask

    task automatic test_render_edges();
        do_reset();
        RenderEnd = 1'b1;
        repeat (20) tick();
        RenderEnd = 1'b0;
        settle("hold");
        push("hold", "FrameCount", 8'h01);
        push("hold", "Overrun", 8'h00);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = port_val(e.port); n_vec++;
            if (o !== e.val) begin n_bad++; $display("FAIL %s %s: got %h want %h", e.scen, e.port, o, e.val); end
        end
        do_reset();
        pulse_render();
        pulse_render();
        pulse_render();
        push("edges_in_clear", "Overrun", 8'h01);
        push("edges_in_clear", "Busy", 8'h01);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = port_val(e.port); n_vec++;
            if (o !== e.val) begin n_bad++; $display("FAIL %s %s: got %h want %h", e.scen, e.port, o, e.val); end
        end
        settle("edges");
        push("edges_done", "FrameCount", 8'h02);
        push("edges_done", "Overrun", 8'h01);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = port_val(e.port); n_vec++;
            if (o !== e.val) begin n_bad++; $display("FAIL %s %s: got %h want %h", e.scen, e.port, o, e.val); end
        end
    endtask

    task automatic test_auto_scan();
        bit found = 1'b0;
        do_reset();
        ManualSel = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = (RowSel == 8'h02);
        end
        n_vec++;
        if (!found) begin
            n_bad++;
            $display("FAIL scan_start: RowSel got %h want 02 within 20 cycles", RowSel);
        end else begin
            for (int c = 0; c < 36; c++)
                push($sformatf("scan_c%0d", c), "RowSel", 8'(1 << ((1 + c / 4) % 8)));
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front(); o = port_val(e.port); n_vec++;
                if (o !== e.val) begin n_bad++; $display("FAIL %s %s: got %h want %h", e.scen, e.port, o, e.val); end
                tick();
            end
        end
        ManualSel = 1'b1;
    endtask

    task automatic test_reset_mid_clear();
        do_reset();
        sel = 3'd4;
        for (int y = 0; y < 8; y++) write_px(3'd4, 3'(y));
        pulse_render();
        repeat (4) tick();
        push("pre_reset", "LED", 8'hFF);
        push("pre_reset", "Busy", 8'h01);
        push("pre_reset", "FrameCount", 8'h01);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = port_val(e.port); n_vec++;
            if (o !== e.val) begin n_bad++; $display("FAIL %s %s: got %h want %h", e.scen, e.port, o, e.val); end
        end
        ARESETn = 1'b0;
        #1;
        push("in_reset", "LED", 8'h00);
        push("in_reset", "RowSel", 8'h01);
        push("in_reset", "Busy", 8'h00);
        push("in_reset", "FrameCount", 8'h00);
        push("in_reset", "Overrun", 8'h00);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = port_val(e.port); n_vec++;
            if (o !== e.val) begin n_bad++; $display("FAIL %s %s: got %h want %h", e.scen, e.port, o, e.val); end
        end
        tick();
        ARESETn = 1'b1;
        repeat (2) tick();
        push("post_reset", "Busy", 8'h00);
        push("post_reset", "RowSel", 8'h10);
        push("post_reset", "LED", 8'h00);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = port_val(e.port); n_vec++;
            if (o !== e.val) begin n_bad++; $display("FAIL %s %s: got %h want %h", e.scen, e.port, o, e.val); end
        end
        pulse_render();
        settle("post_reset_swap");
        push("post_reset_swap", "LED", 8'h00);
        push("post_reset_swap", "FrameCount", 8'h01);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = port_val(e.port); n_vec++;
            if (o !== e.val) begin n_bad++; $display("FAIL %s %s: got %h want %h", e.scen, e.port, o, e.val); end
        end
    endtask

    initial begin
        test_reset();
        test_swap_clear();
        test_pending_write();
        test_render_edges();
        test_auto_scan();
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
